gme_lookup_arb: RTL



---
 rtl/gme_arb_pkg.sv | 18 +
 rtl/arb_sync_fifo.sv | 56 +++++
 rtl/gme_lookup_arb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gme_arb_pkg.sv
// Shared widths and status-word layout for the lookup arbiter.
package gme_arb_pkg;

  localparam int KEY_W    = 512;
  localparam int IDX_W    = 16;
  localparam int REQ_ID_W = 1;

  // out_arb_status bit positions
  localparam int ST_KEY0_ALF      = 0;
  localparam int ST_KEY1_ALF      = 1;
  localparam int ST_ISSUE_BLK     = 2;
  localparam int ST_LAST_GRANT    = 3;
  localparam int ST_TAG_USEDW_LSB = 8;
  localparam int ST_TAG_USEDW_W   = 8;
  localparam int ST_ORPHAN_LSB    = 16;
  localparam int ST_ORPHAN_W      = 16;

endpackage

// File: rtl/arb_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Writes into a full FIFO and
// reads from an empty FIFO are ignored; pointers wrap modulo DEPTH.
module arb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   usedw
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_usedw;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_usedw == '0);
  assign full   = (r_usedw == (AW+1)'(DEPTH));
  assign usedw  = r_usedw;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  // storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_usedw <= r_usedw + 1'b1;
        2'b01:   r_usedw <= r_usedw - 1'b1;
        default: r_usedw <= r_usedw;
      endcase
    end
  end

endmodule

// File: rtl/gme_lookup_arb.sv
// Shares one lookup engine between two key requesters. Keys are buffered per
// requester, granted round-robin, and each grant's source is queued in an
// in-order tag FIFO so returning indices can be steered back.
module gme_lookup_arb
  import gme_arb_pkg::*;
#(
  parameter int KEY_FIFO_DEPTH = 8,
  parameter int TAG_FIFO_DEPTH = 32,
  parameter int KEY_ALF_LEVEL  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_arb_key0_wr,
  input  logic [511:0]     in_arb_key0,
  output logic             out_arb_key0_alf,
  input  logic             in_arb_key1_wr,
  input  logic [511:0]     in_arb_key1,
  output logic             out_arb_key1_alf,
  output logic             out_arb_index0_wr,
  output logic [15:0]      out_arb_index0,
  input  logic             in_arb_index0_alf,
  output logic             out_arb_index1_wr,
  output logic [15:0]      out_arb_index1,
  input  logic             in_arb_index1_alf,
  output logic             out_arb_key_wr,
  output logic [511:0]     out_arb_key,
  input  logic             in_arb_key_alf,
  input  logic             in_arb_index_wr,
  input  logic [15:0]      in_arb_index,
  output logic [31:0]      out_arb_status
);

  localparam int KAW = $clog2(KEY_FIFO_DEPTH);
  localparam int TAW = $clog2(TAG_FIFO_DEPTH);

  logic [KEY_W-1:0]    w_k0_dout, w_k1_dout;
  logic                w_k0_empty, w_k1_empty;
  logic                w_k0_full, w_k1_full;
  logic [KAW:0]        w_k0_usedw, w_k1_usedw;
  logic [REQ_ID_W-1:0] w_tag_dout;
  logic                w_tag_empty, w_tag_full;
  logic [TAW:0]        w_tag_usedw;

  logic                w_elig0, w_elig1, w_issue_en, w_issue_blk;
  logic                w_gnt_vld;
  logic [REQ_ID_W-1:0] w_gnt_id;
  logic                w_tag_pop, w_orphan;
  logic [31:0]         w_status;

  logic                r_key_wr;
  logic [KEY_W-1:0]    r_key;
  logic                r_idx0_wr, r_idx1_wr;
  logic [IDX_W-1:0]    r_idx0, r_idx1;
  logic [REQ_ID_W-1:0] r_last_grant;
  logic [15:0]         r_orphan_cnt;
  logic [31:0]         r_status;

  arb_sync_fifo #(.WIDTH(KEY_W), .DEPTH(KEY_FIFO_DEPTH)) u_key0_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (in_arb_key0_wr && !w_k0_full),
    .din   (in_arb_key0),
    .rd_en (w_gnt_vld && (w_gnt_id == 1'b0)),
    .dout  (w_k0_dout),
    .empty (w_k0_empty),
    .full  (w_k0_full),
    .usedw (w_k0_usedw)
  );

  arb_sync_fifo #(.WIDTH(KEY_W), .DEPTH(KEY_FIFO_DEPTH)) u_key1_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (in_arb_key1_wr && !w_k1_full),
    .din   (in_arb_key1),
    .rd_en (w_gnt_vld && (w_gnt_id == 1'b1)),
    .dout  (w_k1_dout),
    .empty (w_k1_empty),
    .full  (w_k1_full),
    .usedw (w_k1_usedw)
  );

  // a pop on an empty tag FIFO is ignored inside, so a same-cycle push
  // never serves the pop and the index is counted as an orphan instead
  arb_sync_fifo #(.WIDTH(REQ_ID_W), .DEPTH(TAG_FIFO_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (w_gnt_vld),
    .din   (w_gnt_id),
    .rd_en (in_arb_index_wr),
    .dout  (w_tag_dout),
    .empty (w_tag_empty),
    .full  (w_tag_full),
    .usedw (w_tag_usedw)
  );

  assign out_arb_key0_alf = (w_k0_usedw >= (KAW+1)'(KEY_ALF_LEVEL));
  assign out_arb_key1_alf = (w_k1_usedw >= (KAW+1)'(KEY_ALF_LEVEL));

  assign w_elig0     = !w_k0_empty && !in_arb_index0_alf;
  assign w_elig1     = !w_k1_empty && !in_arb_index1_alf;
  assign w_issue_en  = !in_arb_key_alf && !w_tag_full;
  assign w_issue_blk = !w_issue_en;
  assign w_tag_pop   = in_arb_index_wr && !w_tag_empty;
  assign w_orphan    = in_arb_index_wr && w_tag_empty;

  // round-robin grant: on contention the requester not granted last wins
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    if (w_issue_en) begin
      if (w_elig0 && w_elig1) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ~r_last_grant;
      end else if (w_elig0) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b0;
      end else if (w_elig1) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b1;
      end
    end
  end

  // status word assembled from current state; registered below
  always_comb begin
    w_status = '0;
    w_status[ST_KEY0_ALF]   = out_arb_key0_alf;
    w_status[ST_KEY1_ALF]   = out_arb_key1_alf;
    w_status[ST_ISSUE_BLK]  = w_issue_blk;
    w_status[ST_LAST_GRANT] = r_last_grant[0];
    w_status[ST_TAG_USEDW_LSB +: ST_TAG_USEDW_W] = ST_TAG_USEDW_W'(w_tag_usedw);
    w_status[ST_ORPHAN_LSB +: ST_ORPHAN_W]       = r_orphan_cnt;
  end

  // lookup-side key output register; key data holds between issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_wr     <= 1'b0;
      r_key        <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_key_wr <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_key        <= (w_gnt_id == 1'b1) ? w_k1_dout : w_k0_dout;
        r_last_grant <= w_gnt_id;
      end
    end
  end

  // index steering by popped tag; index data holds when not written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx0_wr <= 1'b0;
      r_idx1_wr <= 1'b0;
      r_idx0    <= '0;
      r_idx1    <= '0;
    end else begin
      r_idx0_wr <= w_tag_pop && (w_tag_dout == 1'b0);
      r_idx1_wr <= w_tag_pop && (w_tag_dout == 1'b1);
      if (w_tag_pop && (w_tag_dout == 1'b0)) r_idx0 <= in_arb_index;
      if (w_tag_pop && (w_tag_dout == 1'b1)) r_idx1 <= in_arb_index;
    end
  end

  // saturating orphan counter and one-cycle-stale status register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_orphan_cnt <= '0;
      r_status     <= '0;
    end else begin
      if (w_orphan && (r_orphan_cnt != 16'hFFFF)) r_orphan_cnt <= r_orphan_cnt + 1'b1;
      r_status <= w_status;
    end
  end

  assign out_arb_key_wr    = r_key_wr;
  assign out_arb_key       = r_key;
  assign out_arb_index0_wr = r_idx0_wr;
  assign out_arb_index0    = r_idx0;
  assign out_arb_index1_wr = r_idx1_wr;
  assign out_arb_index1    = r_idx1;
  assign out_arb_status    = r_status;

endmodule
